fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 Clocking and reset: one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 imem_addr  output  32  fetch address, equal to PC.
REQ-006 imem_rdata  input  32  instruction at imem_addr, combinational read, valid in the same cycle.
REQ-007 ex_mem_read  input  1  MemRead of the instruction currently in EX.
REQ-008 ex_rt  input  5  destination register (rt) of the instruction in EX.
REQ-009 branch_taken  input  1  taken branch resolved in EX this cycle.
REQ-010 branch_target  input  32  redirect address, valid when branch_taken=1.
REQ-011 id_inst  output  32  IF/ID instruction register; feeds the decoder.
REQ-012 id_pc_plus4  output  32  IF/ID PC+4 register.
REQ-013 id_valid  output  1  IF/ID holds a live instruction.
REQ-014 stall  output  1  load-use hazard; downstream inserts an ID/EX bubble.
REQ-015 stall_cnt  output  16  saturating count of stall cycles.
REQ-016 flush_cnt  output  16  saturating count of branch redirects.

Function
REQ-017 The source-register rule SHALL be: rs is a source for R-type, BEQ, BNE, ADDI, ANDI, ORI, XORI, LW and SW; rt is a source only for R-type, BEQ, BNE and SW.
REQ-018 Raw hazard SHALL be asserted when all of the following hold: id_valid=1, ex_mem_read=1, ex_rt!=0, and ex_rt equals a source register of id_inst.
REQ-019 stall SHALL be combinational and equal raw hazard AND NOT branch_taken.
REQ-020 The next-state priority SHALL be: branch_taken, then stall, then normal advance.
REQ-021 Branch behaviour: PC <= {branch_target[31:2],2'b00}; id_inst <= 32'h0; id_valid <= 0; id_pc_plus4 holds.
REQ-022 Stall behaviour: PC, id_inst, id_pc_plus4 and id_valid SHALL all hold.
REQ-023 Normal advance: PC <= PC+4; id_inst <= imem_rdata; id_pc_plus4 <= PC+4; id_valid <= 1.
REQ-024 PC+4 SHALL wrap modulo 2^32, so that 32'hFFFF_FFFC advances to 32'h0000_0000.
REQ-025 PC[1:0] SHALL always be 2'b00.
REQ-026 A fetch-to-ID latency of one cycle SHALL apply: the word fetched at PC=A appears on id_inst on the next edge when no branch or stall occurs.
REQ-027 stall_cnt SHALL increment on each edge with stall=1 and saturate at 16'hFFFF.
REQ-028 flush_cnt SHALL increment on each edge with branch_taken=1 and saturate at 16'hFFFF.
REQ-029 When branch_taken and the hazard coincide, the branch SHALL win: no stall is counted, and the flush is counted.
REQ-030 Squashing of the instruction already in ID on a branch SHALL be the responsibility of the ID/EX stage, which uses branch_taken directly.

Reset
REQ-031 On rst_n=0, asynchronously: PC=RESET_PC, id_inst=32'h0, id_pc_plus4=32'h0, id_valid=0, stall_cnt=0, flush_cnt=0.
REQ-032 While id_valid=0 after reset, stall SHALL read 0.
REQ-033 Reset asserted mid-stall or mid-branch SHALL discard the pending update.
REQ-034 The first fetch after rst_n rises SHALL be at RESET_PC.

Structure
REQ-035 The shared package mips_pkg SHALL hold: opcode constants (R-type, BEQ, BNE, ADDI, ANDI, ORI, XORI, LW, SW), the NOP word 32'h0, and the default RESET_PC.
REQ-036 The hazard logic SHALL be the combinational sub-module hazard_detect (id_inst, id_valid, ex_mem_read, ex_rt -> raw hazard), instantiated once.
REQ-037 PC, the IF/ID registers and the counters SHALL reside in fetch_unit.

Verification
REQ-038 Reset and sequential fetch: release reset with imem returning addr-dependent words -> imem_addr steps 0,4,8; id_inst tracks one cycle behind; id_pc_plus4 = 4,8,C.
REQ-039 Load-use on rs: EX holds LW rt=5 and ID holds ADD rs=5 -> stall=1 for one cycle, PC and id_inst hold, stall_cnt=1.
REQ-040 False hazard suppressed: ex_rt=0, or ID holds ADDI with rt=5 against EX LW rt=5 -> stall=0.
REQ-041 Branch with simultaneous hazard: branch_taken=1, target 32'h0000_0043, hazard present -> PC=32'h0000_0040, id_valid=0, stall=0, flush_cnt+1, stall_cnt unchanged.
REQ-042 Wrap and saturation: PC=32'hFFFF_FFFC advances to 0; stall_cnt forced to 16'hFFFF plus another stall -> remains 16'hFFFF; rst_n pulsed low mid-stall -> all registers at reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS-style front end.
//
// Holds the primary opcode encodings the hazard logic cares about, the NOP
// word, the default reset PC, and helpers that say which register fields
// an instruction actually reads.
package mips_pkg;

  // Primary opcode field (inst[31:26]).
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // All-zero word. It decodes as an R-type reading r0, so it can never
  // match a nonzero load destination.
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Register fields pulled out of an instruction word.
  typedef struct packed {
    logic [5:0] opcode;
    logic [4:0] rs;
    logic [4:0] rt;
  } inst_fields_t;

  function automatic inst_fields_t decode_fields(input logic [31:0] inst);
    inst_fields_t f;
    f.opcode = inst[31:26];
    f.rs     = inst[25:21];
    f.rt     = inst[20:16];
    return f;
  endfunction

  // rs is read by every instruction class this front end recognises.
  function automatic logic reads_rs(input logic [5:0] opcode);
    logic r;
    case (opcode)
      OP_RTYPE, OP_BEQ, OP_BNE, OP_ADDI, OP_ANDI,
      OP_ORI, OP_XORI, OP_LW, OP_SW: r = 1'b1;
      default:                       r = 1'b0;
    endcase
    return r;
  endfunction

  // rt is a source only where it is not the destination: R-type, the two
  // compare-branches, and the store data operand.
  function automatic logic reads_rt(input logic [5:0] opcode);
    logic r;
    case (opcode)
      OP_RTYPE, OP_BEQ, OP_BNE, OP_SW: r = 1'b1;
      default:                         r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/fetch_unit_hazard_detect.sv
// hazard_detect: combinational load-use hazard check.
//
// Ports:
//   id_inst     in  32  instruction held in IF/ID
//   id_valid    in  1   IF/ID holds a live instruction
//   ex_mem_read in  1   instruction in EX is a load
//   ex_rt       in  5   load destination register in EX
//   raw_hazard  out 1   ID reads the register the EX load is about to write
module hazard_detect
  import mips_pkg::*;
(
  input  logic [31:0] id_inst,
  input  logic        id_valid,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rt,
  output logic        raw_hazard
);

  inst_fields_t f;
  logic         rs_match;
  logic         rt_match;
  logic         unused_low_bits;

  assign f = decode_fields(id_inst);

  // Immediate / rd / shamt / funct bits play no part in the check.
  assign unused_low_bits = ^id_inst[15:0];

  assign rs_match = reads_rs(f.opcode) && (f.rs == ex_rt);
  assign rt_match = reads_rt(f.opcode) && (f.rt == ex_rt);

  // r0 is hardwired to zero, so a load "into" r0 never creates a dependency.
  assign raw_hazard = id_valid && ex_mem_read && (ex_rt != 5'd0) &&
                      (rs_match || rt_match);

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC register, IF/ID pipeline register, load-use stall and
// branch redirect for a classic 5-stage MIPS-style pipeline.
//
// Ports:
//   clk, rst_n     clock and asynchronous active-low reset
//   imem_addr      out 32  fetch address (the PC)
//   imem_rdata     in  32  combinational instruction memory read data
//   ex_mem_read    in  1   EX instruction is a load
//   ex_rt          in  5   EX load destination register
//   branch_taken   in  1   taken branch resolved in EX this cycle
//   branch_target  in  32  redirect address when branch_taken
//   id_inst        out 32  IF/ID instruction
//   id_pc_plus4    out 32  IF/ID PC+4
//   id_valid       out 1   IF/ID holds a live instruction
//   stall          out 1   load-use stall (ID/EX inserts a bubble)
//   stall_cnt      out 16  saturating count of stall cycles
//   flush_cnt      out 16  saturating count of branch redirects
//
// Update priority each edge: branch redirect, then stall, then advance.
// On a redirect the instruction sitting in ID is squashed downstream by
// the ID/EX stage looking at branch_taken itself; here IF/ID is simply
// refilled with a NOP and marked invalid.
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rt,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc_plus4,
  output logic        id_valid,
  output logic        stall,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  // Word-aligned reset address; the low two bits of PC are never stored
  // as anything but zero.
  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        raw_hazard;
  logic        unused_target_bits;

  hazard_detect u_hazard_detect (
    .id_inst     (id_inst),
    .id_valid    (id_valid),
    .ex_mem_read (ex_mem_read),
    .ex_rt       (ex_rt),
    .raw_hazard  (raw_hazard)
  );

  // A redirect discards whatever is in ID, so a hazard on it is moot.
  assign stall = raw_hazard && !branch_taken;

  // Natural 32-bit overflow gives the required wrap from FFFF_FFFC to 0.
  assign pc_plus4  = pc + 32'd4;
  assign imem_addr = pc;

  // Target bits [1:0] are dropped when aligning the redirect.
  assign unused_target_bits = ^branch_target[1:0];

  // PC and IF/ID registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC_ALIGNED;
      id_inst     <= NOP_WORD;
      id_pc_plus4 <= 32'h0000_0000;
      id_valid    <= 1'b0;
    end else if (branch_taken) begin
      pc       <= {branch_target[31:2], 2'b00};
      id_inst  <= NOP_WORD;
      id_valid <= 1'b0;
      // id_pc_plus4 deliberately holds.
    end else if (stall) begin
      // Everything holds; the bubble is inserted at ID/EX.
      pc          <= pc;
      id_inst     <= id_inst;
      id_pc_plus4 <= id_pc_plus4;
      id_valid    <= id_valid;
    end else begin
      pc          <= pc_plus4;
      id_inst     <= imem_rdata;
      id_pc_plus4 <= pc_plus4;
      id_valid    <= 1'b1;
    end
  end

  // Saturating event counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= 16'h0000;
      flush_cnt <= 16'h0000;
    end else begin
      if (stall && (stall_cnt != 16'hFFFF)) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
      if (branch_taken && (flush_cnt != 16'hFFFF)) begin
        flush_cnt <= flush_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        ex_mem_read;
  logic [4:0]  ex_rt;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] id_inst;
  logic [31:0] id_pc_plus4;
  logic        id_valid;
  logic        stall;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  int checks;
  int failures;

  // Expected {id_inst, id_pc_plus4}, pushed when a fetch is issued.
  logic [63:0] exp_q[$];

  logic [31:0] exp_pc;
  logic [15:0] exp_stall;
  logic [15:0] exp_flush;

  logic        ovr_en;
  logic [31:0] ovr_word;

  // ADD r7, r5, r6
  localparam logic [31:0] INST_ADD_RS5  = {6'h00, 5'd5, 5'd6, 5'd7, 5'd0, 6'h20};
  // SW r5, 0(r1)
  localparam logic [31:0] INST_SW_RT5   = {6'h2B, 5'd1, 5'd5, 16'h0000};
  // ADDI r5, r1, 16  (rt=5 is a destination, not a source)
  localparam logic [31:0] INST_ADDI_RT5 = {6'h08, 5'd1, 5'd5, 16'h0010};

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .ex_mem_read   (ex_mem_read),
    .ex_rt         (ex_rt),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .id_inst       (id_inst),
    .id_pc_plus4   (id_pc_plus4),
    .id_valid      (id_valid),
    .stall         (stall),
    .stall_cnt     (stall_cnt),
    .flush_cnt     (flush_cnt)
  );

  // ---------------- clock / memory model ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hC0DE_0000 ^ a;
  endfunction

  always_comb begin
    imem_rdata = ovr_en ? ovr_word : mem_word(imem_addr);
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One normal-advance cycle with scoreboard push/pop.
  task automatic adv(input string name);
    logic [63:0] e;
    logic [31:0] w;
    checks++;
    if (imem_addr !== exp_pc) begin
      failures++;
      $display("FAIL %s.fetch_addr actual=%h expected=%h", name, imem_addr, exp_pc);
    end
    w = ovr_en ? ovr_word : mem_word(exp_pc);
    exp_q.push_back({w, exp_pc + 32'd4});
    step();
    exp_pc = exp_pc + 32'd4;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s.queue_empty", name);
    end else begin
      e = exp_q.pop_front();
      if ({id_inst, id_pc_plus4, id_valid} !== {e, 1'b1}) begin
        failures++;
        $display("FAIL %s.ifid actual=%h/%h/%b expected=%h/%h/1", name,
                 id_inst, id_pc_plus4, id_valid, e[63:32], e[31:0]);
      end
    end
  endtask

  // Put a specific instruction into ID via a normal advance.
  task automatic load_id(input logic [31:0] inst, input string name);
    ovr_en   = 1'b1;
    ovr_word = inst;
    adv(name);
    ovr_en   = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; ex_mem_read = 1'b1; ex_rt = 5'd5;
    branch_taken = 1'b0; branch_target = 32'h0;
    ovr_en = 1'b0; ovr_word = 32'h0;
    #12;
    checks++;
    if ({imem_addr, id_inst, id_pc_plus4, id_valid} !== {32'h0, 32'h0, 32'h0, 1'b0}) begin
      failures++;
      $display("FAIL reset.regs actual=%h/%h/%h/%b expected=0/0/0/0",
               imem_addr, id_inst, id_pc_plus4, id_valid);
    end
    checks++;
    if ({stall_cnt, flush_cnt, stall} !== 33'h0) begin
      failures++;
      $display("FAIL reset.cnt_stall actual=%h/%h/%b expected=0/0/0", stall_cnt, flush_cnt, stall);
    end
    ex_mem_read = 1'b0; ex_rt = 5'd0;
    rst_n = 1'b1;
    exp_pc = 32'h0; exp_stall = 16'h0; exp_flush = 16'h0;
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 3; i++) adv("seq");
    checks++;
    if (id_pc_plus4 !== 32'h0000_000C) begin
      failures++;
      $display("FAIL seq.pc4_c actual=%h expected=0000000c", id_pc_plus4);
    end
  endtask

  task automatic test_load_use();
    logic [31:0] held;
    // rs dependency
    load_id(INST_ADD_RS5, "lu_load");
    held = id_inst;
    ex_mem_read = 1'b1; ex_rt = 5'd5;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      failures++;
      $display("FAIL lu.stall_rs actual=%b expected=1", stall);
    end
    step();
    exp_stall++;
    checks++;
    if ({imem_addr, id_inst, stall_cnt} !== {exp_pc, held, exp_stall}) begin
      failures++;
      $display("FAIL lu.hold actual=%h/%h/%h expected=%h/%h/%h",
               imem_addr, id_inst, stall_cnt, exp_pc, held, exp_stall);
    end
    ex_mem_read = 1'b0;
    adv("lu_resume");
    // rt dependency through store data
    load_id(INST_SW_RT5, "lu_sw");
    ex_mem_read = 1'b1; ex_rt = 5'd5;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      failures++;
      $display("FAIL lu.stall_rt actual=%b expected=1", stall);
    end
    step();
    exp_stall++;
    checks++;
    if (stall_cnt !== exp_stall) begin
      failures++;
      $display("FAIL lu.cnt_rt actual=%h expected=%h", stall_cnt, exp_stall);
    end
    ex_mem_read = 1'b0;
    adv("lu_resume2");
  endtask

  task automatic test_false_hazard();
    load_id(INST_ADD_RS5, "fh_add");
    ex_mem_read = 1'b1; ex_rt = 5'd0;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      failures++;
      $display("FAIL fh.rt_zero actual=%b expected=0", stall);
    end
    ex_mem_read = 1'b0; ex_rt = 5'd5;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      failures++;
      $display("FAIL fh.no_load actual=%b expected=0", stall);
    end
    load_id(INST_ADDI_RT5, "fh_addi");
    ex_mem_read = 1'b1; ex_rt = 5'd5;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      failures++;
      $display("FAIL fh.addi_rt actual=%b expected=0", stall);
    end
    adv("fh_advance");
    ex_mem_read = 1'b0; ex_rt = 5'd0;
  endtask

  task automatic test_branch_hazard();
    logic [31:0] held_pc4;
    load_id(INST_ADD_RS5, "br_load");
    held_pc4 = exp_pc;
    ex_mem_read = 1'b1; ex_rt = 5'd5;
    branch_taken = 1'b1; branch_target = 32'h0000_0043;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      failures++;
      $display("FAIL br.stall actual=%b expected=0", stall);
    end
    step();
    exp_flush++;
    exp_pc = 32'h0000_0040;
    branch_taken = 1'b0;
    checks++;
    if ({imem_addr, id_inst, id_valid, id_pc_plus4} !== {exp_pc, 32'h0, 1'b0, held_pc4}) begin
      failures++;
      $display("FAIL br.redirect actual=%h/%h/%b/%h expected=%h/0/0/%h",
               imem_addr, id_inst, id_valid, id_pc_plus4, exp_pc, held_pc4);
    end
    checks++;
    if ({flush_cnt, stall_cnt, stall} !== {exp_flush, exp_stall, 1'b0}) begin
      failures++;
      $display("FAIL br.counts actual=%h/%h/%b expected=%h/%h/0",
               flush_cnt, stall_cnt, stall, exp_flush, exp_stall);
    end
    ex_mem_read = 1'b0; ex_rt = 5'd0;
    adv("br_target_fetch");
  endtask

  task automatic test_wrap();
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
    step();
    branch_taken = 1'b0;
    exp_flush++;
    exp_pc = 32'hFFFF_FFFC;
    adv("wrap");
    checks++;
    if ({imem_addr, id_pc_plus4, flush_cnt} !== {32'h0, 32'h0, exp_flush}) begin
      failures++;
      $display("FAIL wrap.zero actual=%h/%h/%h expected=0/0/%h",
               imem_addr, id_pc_plus4, flush_cnt, exp_flush);
    end
  endtask

  task automatic test_stall_saturation();
    int n;
    load_id(INST_ADD_RS5, "sat_load");
    ex_mem_read = 1'b1; ex_rt = 5'd5;
    n = 65535 - int'(exp_stall);
    repeat (n) step();
    exp_stall = 16'hFFFF;
    checks++;
    if ({stall_cnt, stall} !== {exp_stall, 1'b1}) begin
      failures++;
      $display("FAIL sat.reach actual=%h/%b expected=ffff/1", stall_cnt, stall);
    end
    step();
    checks++;
    if ({stall_cnt, imem_addr} !== {16'hFFFF, exp_pc}) begin
      failures++;
      $display("FAIL sat.hold actual=%h/%h expected=ffff/%h", stall_cnt, imem_addr, exp_pc);
    end
  endtask

  task automatic test_reset_mid_stall();
    // Currently stalled, 1 time unit past an edge; next edge is 9 away.
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({imem_addr, id_inst, id_pc_plus4, id_valid} !== {32'h0, 32'h0, 32'h0, 1'b0}) begin
      failures++;
      $display("FAIL rst_mid.regs actual=%h/%h/%h/%b expected=0/0/0/0",
               imem_addr, id_inst, id_pc_plus4, id_valid);
    end
    checks++;
    if ({stall_cnt, flush_cnt, stall} !== 33'h0) begin
      failures++;
      $display("FAIL rst_mid.cnt actual=%h/%h/%b expected=0/0/0", stall_cnt, flush_cnt, stall);
    end
    ex_mem_read = 1'b0; ex_rt = 5'd0;
    step();
    rst_n = 1'b1;
    exp_pc = 32'h0; exp_stall = 16'h0; exp_flush = 16'h0;
    exp_q.delete();
    adv("post_reset");
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_sequential();
    test_load_use();
    test_false_hazard();
    test_branch_hazard();
    test_wrap();
    test_stall_saturation();
    test_reset_mid_stall();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL final.queue actual=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
